mem_cmd_engine: RTL and testbench
=================================

Name: mem_cmd_engine

Overview:
- Sits on the clk_mem side between the asynchronous FIFO read port and the BRAM.
- Pops bytes from the FIFO, parses a byte-stream command protocol (header, address, optional data) and performs burst writes and reads on the BRAM.
- Returns read bytes on a valid/ready stream, replacing the direct FIFO-to-BRAM wiring in the current top level.

Parameters:
- ADDR_W, 8, BRAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, FIFO byte width and BRAM data width.
- LEN_W, 6, header burst-length field width; fixed at DATA_W-2.

Ports:
- clk_mem  in  1  memory-domain clock.
- reset  in  1  active-low, asynchronous reset; all registers clear immediately on assertion.
- fifo_data_out  in  DATA_W  FIFO read data; registered, valid the cycle after fifo_r_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_r_en  out  1  FIFO pop strobe.
- bram_addr  out  ADDR_W  BRAM address (registered).
- bram_wdata  out  DATA_W  BRAM write data (registered).
- bram_we  out  1  BRAM write strobe (registered); 0 selects read.
- bram_rdata  in  DATA_W  BRAM read data; 1-cycle synchronous latency.
- rd_data  out  DATA_W  read-return byte.
- rd_valid  out  1  rd_data valid; held until rd_ready.
- rd_ready  in  1  downstream accepts rd_data.
- busy  out  1  high whenever the FSM is not in S_HDR.
- cmd_done  out  1  one-cycle pulse when a WRITE or READ command completes.
- err_illegal  out  1  sticky; set by an illegal opcode, cleared only by reset.

Behaviour:
- Reset: all outputs 0; FSM in S_HDR; in-flight FIFO byte discarded.
- Byte adapter (sub-module):
  - Pulses fifo_r_en only when !fifo_empty, no byte is held, and no pop is in flight.
  - Captures fifo_data_out the next cycle into a holding register and presents it as b_valid/b_data.
  - Releases the byte on b_ready.
  - Maximum rate is 1 byte per 2 cycles; fifo_r_en is never asserted while fifo_empty=1.
- Header byte: op = hdr[7:6], len = hdr[5:0]+1 (1..64).
  - op 00 NOP: consumed, no action.
  - op 01 WRITE.
  - op 10 READ.
  - op 11 ILLEGAL: consumed, err_illegal set, return to S_HDR.
- FSM states:
  - S_HDR: accept byte and decode. WRITE or READ goes to S_ADDR, latching op and cnt=len.
  - S_ADDR: accept byte into addr. WRITE goes to S_WDATA; READ goes to S_RD_ISSUE.
  - S_WDATA: accept byte.
    - Next cycle: bram_we=1, bram_addr=addr, bram_wdata=byte, for exactly one cycle.
    - Then addr+=1 (wraps 0xFF to 0x00), cnt-=1.
    - cnt reaches 0: pulse cmd_done and go to S_HDR.
  - S_RD_ISSUE: bram_addr=addr, bram_we=0, then S_RD_WAIT.
  - S_RD_WAIT: one cycle for BRAM latency, then S_RD_OUT with rd_data<=bram_rdata and rd_valid<=1.
  - S_RD_OUT: hold rd_data/rd_valid stable until rd_ready.
    - On handshake: rd_valid<=0, addr+=1 (wrap), cnt-=1.
    - cnt reaches 0: pulse cmd_done and go to S_HDR; otherwise go to S_RD_ISSUE.
- b_ready is asserted only in S_HDR, S_ADDR and S_WDATA. In read states the FIFO is not drained beyond the one byte held in the adapter.
- FIFO stall (empty) mid-command: FSM waits indefinitely in the current state; no timeout.
- Reset asserted mid-burst: partial burst abandoned, no further bram_we. The first byte after reset release is parsed as a header.
- bram_we and a read address are never driven in the same cycle.

Decomposition:
- Shared package mem_cmd_pkg:
  - opcode constants OP_NOP=2'b00, OP_WR=2'b01, OP_RD=2'b10, OP_ILL=2'b11.
  - state enum/localparams S_HDR, S_ADDR, S_WDATA, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT.
  - Header field positions.
- One sub-module: fifo_rd_adapter, which converts the registered-read FIFO port into a b_valid/b_ready byte stream.

Test Plan:
- Write burst: FIFO bytes 0x42,0x10,0xAA,0xBB,0xCC.
  - Required: bram_we pulses at addr 0x10/0x11/0x12 with data AA/BB/CC.
  - Required: cmd_done pulses once; busy falls.
- Read burst after the write: FIFO 0x82,0x10 with BRAM preloaded.
  - Required: rd_data AA, BB, CC on successive rd_valid handshakes; bram_we stays 0.
- Read backpressure: same read with rd_ready held low 10 cycles.
  - Required: rd_valid=1 and rd_data=0xAA stable throughout.
  - Required: no address advance and no extra FIFO pops.
- Wrap and illegal opcode, two checks:
  - Write 0x41,0xFF,0x11,0x22 → writes 0xFF←0x11 and 0x00←0x22.
  - Then byte 0xC5 → err_illegal=1 and stays 1; next valid command still executes.
- Empty and reset:
  - Header and address only, then FIFO empty → FSM parks in S_WDATA; fifo_r_en never asserted while empty.
  - Assert reset mid-burst → all outputs 0 immediately; no further bram_we; next byte parsed as header.

Source files
------------

// File: rtl/mem_cmd_pkg.sv
`timescale 1ns/1ps
// Shared opcode, FSM state and header-layout definitions for the memory
// command engine.
package mem_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_WR  = 2'b01,
    OP_RD  = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_HDR,
    S_ADDR,
    S_WDATA,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_OUT
  } state_e;

  // Header byte: opcode in the top two bits, (length-1) below it.
  localparam int HDR_OP_MSB  = 7;
  localparam int HDR_OP_W    = 2;
  localparam int HDR_LEN_MSB = 5;

endpackage

// File: rtl/mem_cmd_if.sv
`timescale 1ns/1ps
// Bundles the FIFO read port, BRAM port, read-return stream and status
// signals of the memory command engine.
interface mem_cmd_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] fifo_data_out;
  logic              fifo_empty;
  logic              fifo_r_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              bram_we;
  logic [DATA_W-1:0] bram_rdata;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              busy;
  logic              cmd_done;
  logic              err_illegal;

  modport master (
    input  fifo_data_out, fifo_empty, bram_rdata, rd_ready,
    output fifo_r_en, bram_addr, bram_wdata, bram_we,
           rd_data, rd_valid, busy, cmd_done, err_illegal
  );

  modport slave (
    output fifo_data_out, fifo_empty, bram_rdata, rd_ready,
    input  fifo_r_en, bram_addr, bram_wdata, bram_we,
           rd_data, rd_valid, busy, cmd_done, err_illegal
  );
endinterface

// File: rtl/fifo_rd_adapter.sv
`timescale 1ns/1ps
// Turns the registered-read FIFO port into a one-deep b_valid/b_ready byte
// stream; at most one pop is ever in flight or held.
module fifo_rd_adapter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  output logic              fifo_r_en,
  output logic              b_valid,
  output logic [DATA_W-1:0] b_data,
  input  logic              b_ready
);
  logic              run_q, run_d;
  logic              pend_q, pend_d;
  logic              hold_q, hold_d;
  logic [DATA_W-1:0] data_q, data_d;

  // run_q keeps the pop strobe low while reset is asserted; a byte being
  // released this cycle frees the holding register for the next pop.
  always_comb begin
    fifo_r_en = run_q && !fifo_empty && !pend_q && (!hold_q || b_ready);
    run_d     = 1'b1;
    pend_d    = fifo_r_en;
    hold_d    = hold_q;
    data_d    = data_q;
    if (hold_q && b_ready) begin
      hold_d = 1'b0;
    end
    if (pend_q) begin
      hold_d = 1'b1;
      data_d = fifo_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      pend_q <= 1'b0;
      hold_q <= 1'b0;
      data_q <= '0;
    end else begin
      run_q  <= run_d;
      pend_q <= pend_d;
      hold_q <= hold_d;
      data_q <= data_d;
    end
  end

  assign b_valid = hold_q;
  assign b_data  = data_q;

endmodule

// File: rtl/mem_cmd_engine.sv
`timescale 1ns/1ps
// Parses header/address/data command bytes from the FIFO and performs burst
// writes and reads on the BRAM, returning read bytes on a valid/ready stream.
module mem_cmd_engine
  import mem_cmd_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = DATA_W - 2
) (
  input  logic clk_mem,
  input  logic reset,
  mem_cmd_if.master bus
);
  localparam int CNT_W = LEN_W + 1;

  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  op_e               hdr_op;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_wdata_q, bram_wdata_d;
  logic              bram_we_q, bram_we_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              cmd_done_q, cmd_done_d;
  logic              err_q, err_d;

  fifo_rd_adapter #(.DATA_W(DATA_W)) u_adapter (
    .clk           (clk_mem),
    .rst_n         (reset),
    .fifo_data_out (bus.fifo_data_out),
    .fifo_empty    (bus.fifo_empty),
    .fifo_r_en     (bus.fifo_r_en),
    .b_valid       (b_valid),
    .b_data        (b_data),
    .b_ready       (b_ready)
  );

  assign hdr_op = op_e'(b_data[HDR_OP_MSB -: HDR_OP_W]);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    bram_we_d    = 1'b0;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    cmd_done_d   = 1'b0;
    err_d        = err_q;
    b_ready      = 1'b0;

    unique case (state_q)
      S_HDR: begin
        b_ready = 1'b1;
        if (b_valid) begin
          unique case (hdr_op)
            OP_WR, OP_RD: begin
              op_d    = hdr_op;
              cnt_d   = CNT_W'(b_data[HDR_LEN_MSB:0]) + CNT_W'(1);
              state_d = S_ADDR;
            end
            OP_ILL:  err_d = 1'b1;
            OP_NOP:  ;
            default: ;
          endcase
        end
      end
      S_ADDR: begin
        b_ready = 1'b1;
        if (b_valid) begin
          addr_d = ADDR_W'(b_data);
          if (op_q == OP_WR) begin
            state_d = S_WDATA;
          end else begin
            // Address is registered on entry so the BRAM samples it during S_RD_ISSUE.
            bram_addr_d = ADDR_W'(b_data);
            state_d     = S_RD_ISSUE;
          end
        end
      end
      S_WDATA: begin
        b_ready = 1'b1;
        if (b_valid) begin
          bram_we_d    = 1'b1;
          bram_addr_d  = addr_q;
          bram_wdata_d = b_data;
          addr_d       = addr_q + ADDR_W'(1);
          cnt_d        = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            cmd_done_d = 1'b1;
            state_d    = S_HDR;
          end
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rd_data_d  = bus.bram_rdata;
        rd_valid_d = 1'b1;
        state_d    = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          addr_d     = addr_q + ADDR_W'(1);
          cnt_d      = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            cmd_done_d = 1'b1;
            state_d    = S_HDR;
          end else begin
            bram_addr_d = addr_q + ADDR_W'(1);
            state_d     = S_RD_ISSUE;
          end
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) begin
      state_q      <= S_HDR;
      op_q         <= OP_NOP;
      cnt_q        <= '0;
      addr_q       <= '0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      bram_we_q    <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      cmd_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      bram_we_q    <= bram_we_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      cmd_done_q   <= cmd_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.bram_addr   = bram_addr_q;
  assign bus.bram_wdata  = bram_wdata_q;
  assign bus.bram_we     = bram_we_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.busy        = (state_q != S_HDR);
  assign bus.cmd_done    = cmd_done_q;
  assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_mem_cmd_engine.sv
`timescale 1ns/1ps
// Bench for mem_cmd_engine: FIFO and BRAM models, a command-stream reference
// model, directed scenarios and randomized command traffic.
module tb_mem_cmd_engine;
  import mem_cmd_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_cmd_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_cmd_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk_mem (clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [7:0] pre(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // FIFO model: registered read data, bytes appended by the stimulus.
  logic [7:0] fmem [8192];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (bus.fifo_r_en && !bus.fifo_empty) begin
      bus.fifo_data_out <= fmem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // BRAM model: one-cycle synchronous read, preloaded on the first edge.
  logic [7:0] bram [256];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) bram[i] <= pre(i);
      mem_init <= 1'b1;
    end else if (bus.bram_we) begin
      bram[bus.bram_addr] <= bus.bram_wdata;
    end
    bus.bram_rdata <= bram[bus.bram_addr];
  end

  bit hold_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.rd_ready = hold_rdy ? 1'b0 : ($urandom_range(3) != 0);
  end

  // Reference model: parses the pushed byte stream into expected writes,
  // expected read-return bytes and completed-command count.
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  int   exp_done  = 0;
  int   got_done  = 0;
  bit   model_err = 1'b0;
  int   p_state = 0;
  int   p_op    = 0;
  int   p_cnt   = 0;
  logic [7:0] p_addr = '0;

  task automatic consume(input logic [7:0] b);
    case (p_state)
      0: begin
        if (b[7:6] == 2'b01 || b[7:6] == 2'b10) begin
          p_op    = int'(b[7:6]);
          p_cnt   = int'(b[5:0]) + 1;
          p_state = 1;
        end else if (b[7:6] == 2'b11) begin
          model_err = 1'b1;
        end
      end
      1: begin
        p_addr = b;
        if (p_op == 2) begin
          for (int i = 0; i < p_cnt; i++) exp_rd.push_back(ref_mem[8'(p_addr + 8'(i))]);
          exp_done++;
          p_state = 0;
        end else begin
          p_state = 2;
        end
      end
      default: begin
        exp_wr.push_back({p_addr, b});
        ref_mem[p_addr] = b;
        p_addr = p_addr + 8'd1;
        p_cnt--;
        if (p_cnt == 0) begin
          exp_done++;
          p_state = 0;
        end
      end
    endcase
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk);
    #1;
    fmem[wr_ptr] = b;
    wr_ptr++;
    consume(b);
  endtask

  // Per-cycle compare against the model.
  bit         prev_hold = 1'b0;
  logic [7:0] prev_rd   = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (bus.fifo_r_en) chk("pop_while_empty", 32'(bus.fifo_empty), 32'(0));
      if (bus.bram_we) begin
        chk("write_expected", 32'(exp_wr.size() != 0), 32'(1));
        if (exp_wr.size() != 0) begin
          logic [15:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.bram_addr), 32'(e[15:8]));
          chk("wr_data", 32'(bus.bram_wdata), 32'(e[7:0]));
        end
      end
      if (prev_hold) begin
        chk("rd_valid_held", 32'(bus.rd_valid), 32'(1));
        chk("rd_data_stable", 32'(bus.rd_data), 32'(prev_rd));
      end
      if (bus.rd_valid && bus.rd_ready) begin
        chk("read_expected", 32'(exp_rd.size() != 0), 32'(1));
        if (exp_rd.size() != 0) chk("rd_data", 32'(bus.rd_data), 32'(exp_rd.pop_front()));
      end
      if (bus.cmd_done) got_done++;
      prev_hold = bus.rd_valid && !bus.rd_ready;
      prev_rd   = bus.rd_data;
    end
  end

  task automatic wait_idle(input string tag);
    int quiet;
    int cyc;
    quiet = 0;
    cyc   = 0;
    while (quiet < 6 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (bus.fifo_empty && !bus.busy && !bus.rd_valid) quiet++;
      else quiet = 0;
    end
    chk({tag, "_idle_in_time"}, 32'(cyc < 3000), 32'(1));
    chk({tag, "_writes_drained"}, 32'(exp_wr.size()), 32'(0));
    chk({tag, "_reads_drained"}, 32'(exp_rd.size()), 32'(0));
    chk({tag, "_done_count"}, 32'(got_done), 32'(exp_done));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fifo_r_en"}, 32'(bus.fifo_r_en), 32'(0));
    chk({tag, "_bram_addr"}, 32'(bus.bram_addr), 32'(0));
    chk({tag, "_bram_wdata"}, 32'(bus.bram_wdata), 32'(0));
    chk({tag, "_bram_we"}, 32'(bus.bram_we), 32'(0));
    chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'(0));
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'(0));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "_cmd_done"}, 32'(bus.cmd_done), 32'(0));
    chk({tag, "_err_illegal"}, 32'(bus.err_illegal), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int r0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pre(i);
    #2 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Write burst 0x10..0x12.
    push(8'h42); push(8'h10); push(8'hAA); push(8'hBB); push(8'hCC);
    wait_idle("wr1");
    chk("wr1_mem10", 32'(bram[8'h10]), 32'h0AA);
    chk("wr1_mem11", 32'(bram[8'h11]), 32'h0BB);
    chk("wr1_mem12", 32'(bram[8'h12]), 32'h0CC);
    chk("wr1_done_once", 32'(got_done), 32'(1));
    chk("wr1_busy_low", 32'(bus.busy), 32'(0));

    // Read the same burst back.
    push(8'h82); push(8'h10);
    chk("rd1_model_len", 32'(exp_rd.size()), 32'(3));
    chk("rd1_model_b0", 32'(exp_rd[0]), 32'h0AA);
    chk("rd1_model_b2", 32'(exp_rd[2]), 32'h0CC);
    wait_idle("rd1");

    // Same read with the consumer stalled.
    hold_rdy = 1'b1;
    push(8'h82); push(8'h10); push(8'h00); push(8'h00);
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.rd_valid) seen = 1;
    end
    chk("bp_valid_seen", 32'(seen), 32'(1));
    r0 = rd_ptr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rd_valid", 32'(bus.rd_valid), 32'(1));
      chk("bp_rd_data", 32'(bus.rd_data), 32'h0AA);
      chk("bp_bram_addr", 32'(bus.bram_addr), 32'h010);
      chk("bp_no_pop", 32'(rd_ptr), 32'(r0));
    end
    hold_rdy = 1'b0;
    wait_idle("bp");

    // Address wrap.
    push(8'h41); push(8'hFF); push(8'h11); push(8'h22);
    wait_idle("wrap");
    chk("wrap_memFF", 32'(bram[8'hFF]), 32'h011);
    chk("wrap_mem00", 32'(bram[8'h00]), 32'h022);

    // Illegal opcode is sticky; next command still runs.
    push(8'hC5);
    wait_idle("ill");
    chk("ill_err_set", 32'(bus.err_illegal), 32'(1));
    push(8'h40); push(8'h05); push(8'h99);
    wait_idle("ill_next");
    chk("ill_next_mem05", 32'(bram[8'h05]), 32'h099);
    chk("ill_err_sticky", 32'(bus.err_illegal), 32'(1));

    // Header and address only, then the FIFO runs dry.
    push(8'h43); push(8'h20);
    repeat (20) @(negedge clk);
    chk("park_busy", 32'(bus.busy), 32'(1));
    chk("park_state", 32'(dut.state_q), 32'(S_WDATA));
    chk("park_no_write", 32'(bram[8'h20]), 32'(pre(8'h20)));

    // Reset while parked mid-burst.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("midreset");
    p_state = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h41); push(8'h30); push(8'h77); push(8'h88);
    wait_idle("post_reset");
    chk("post_reset_mem30", 32'(bram[8'h30]), 32'h077);
    chk("post_reset_mem31", 32'(bram[8'h31]), 32'h088);
    chk("post_reset_mem20", 32'(bram[8'h20]), 32'(pre(8'h20)));
    chk("post_reset_err", 32'(bus.err_illegal), 32'(0));

    // Randomized command traffic with FIFO gaps and consumer backpressure.
    for (int c = 0; c < 40; c++) begin
      int k;
      logic [1:0] op;
      logic [2:0] len;
      k   = $urandom_range(9);
      op  = (k < 4) ? 2'b01 : (k < 8) ? 2'b10 : (k == 8) ? 2'b00 : 2'b11;
      len = 3'($urandom_range(7));
      push({op, 3'b000, len});
      if (op == 2'b01 || op == 2'b10) push(8'($urandom_range(255)));
      if (op == 2'b01) begin
        for (int d = 0; d <= int'(len); d++) begin
          push(8'($urandom_range(255)));
          repeat ($urandom_range(2)) @(posedge clk);
        end
      end
      repeat ($urandom_range(3)) @(posedge clk);
    end
    wait_idle("rand");
    chk("rand_err", 32'(bus.err_illegal), 32'(model_err));
    for (int i = 0; i < 256; i++) chk("final_mem", 32'(bram[i]), 32'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
